obstacle_spawn_scheduler: RTL and testbench
===========================================

Name: obstacle_spawn_scheduler

Overview:
Sequences obstacle creation for the runner game. Derives difficulty level, scroll speed and target obstacle count from time_alive. Times the gap between spawns in frames, chooses lane and sprite so no unbeatable pattern appears, and offers each spawn to the obstacle pool over a valid/ready handshake. Sits between the game-state/timer logic and the obstacle pool; it owns all spawn-timing decisions.

Parameters:
NUM_SLOTS, 10, obstacle pool capacity; spawns are never offered when active_count >= NUM_SLOTS
LEVEL_PERIOD, 300, time_alive units per difficulty level
MAX_LEVEL, 10, saturation level
MIN_GAP, 8, minimum frames between spawns (added to random_num)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-low
game_reset  input  1  synchronous, active-high restart; same effect as reset
frame_tick  input  1  one-cycle pulse per video frame
pause_in  input  1  freezes the gap countdown and withholds new offers
time_alive  input  12  frames survived, monotonic except at restart
active_count  input  4  obstacles currently live in the pool
random_num  input  4  random gap extension
random_lane  input  2  random lane; value 3 is invalid
random_sprite  input  2  random sprite type
spawn_ready  input  1  pool accepts the offered spawn
spawn_valid  output  1  spawn offer valid
spawn_lane  output  2  lane of the offer, 0..2
spawn_sprite  output  2  sprite of the offer
speed  output  3  scroll pixels per frame
target_active  output  4  desired live obstacle count (equals level)
level  output  4  current difficulty level, 0..MAX_LEVEL

Behaviour:
- Reset (rst_in==0 or game_reset==1, sampled at the clock edge): FSM to IDLE.
  - Output values: spawn_valid=0, spawn_lane=0, spawn_sprite=0, level=0, target_active=0, speed=1.
  - Internal values: next_threshold=LEVEL_PERIOD, gap counter=0, last_lane=0, repeat_cnt=0.
  - Reset overrides every other input, including a spawn in flight; that offer is dropped.
- Level tracking (no divider):
  - When time_alive >= next_threshold and level < MAX_LEVEL: level += 1 and next_threshold += LEVEL_PERIOD.
  - At most one step per cycle, so a large jump in time_alive catches up at one level per clock.
  - next_threshold is 13 bits wide, which prevents wrap.
- target_active = level, registered in the same cycle as level.
- speed is registered one cycle after level, mapped by level: 0→1, 1→2, 2→3, 3→4, 4..5→5, 6..7→6, 8..10→7.
- FSM states: IDLE, WAIT, PICK, OFFER.
  - IDLE: if active_count < target_active, active_count < NUM_SLOTS and !pause_in, load gap = MIN_GAP + random_num (5-bit, range 8..23) and go to WAIT. Otherwise stay.
  - WAIT:
    - On frame_tick with !pause_in, gap -= 1.
    - When gap == 0 (checked every cycle), go to PICK.
    - If active_count >= NUM_SLOTS, abort to IDLE.
  - PICK (1 cycle): select the lane, latch spawn_lane and spawn_sprite=random_sprite, go to OFFER.
    - Start from lane = random_lane.
    - If random_lane == 3, use lane = (last_lane+1) mod 3.
    - Otherwise, if lane == last_lane and repeat_cnt == 2, use lane = (last_lane+1) mod 3. This caps any lane at 3 consecutive spawns.
  - OFFER: spawn_valid=1, with lane and sprite held stable until handshake.
    - Handshake = spawn_valid && spawn_ready. On handshake: spawn_valid deasserts the next cycle and the FSM returns to IDLE.
    - On handshake, repeat_cnt = (lane == last_lane) ? repeat_cnt+1 : 0, then last_lane = lane.
    - pause_in does not withdraw an offer already in OFFER.
- Latency: a gap expiry that is not stalled produces spawn_valid 2 cycles after gap reaches 0 (PICK, then OFFER).
- Minimum spacing between two accepted spawns is MIN_GAP frame_ticks.
- Simultaneous frame_tick and state entry into WAIT: that tick is not counted.
- active_count decreasing while in WAIT does not restart the countdown.

Test Plan:
- Reset: hold rst_in=0 for 3 clocks with time_alive=900 → spawn_valid=0, level=0, speed=1. Release → level reaches 3 after 3 clocks and speed=4 one clock later.
- Level saturation: time_alive=4000 → level stops at 10, target_active=10, speed=7, next_threshold does not wrap.
- Gap timing: level=2, active_count=0, random_num=5, frame_tick every 4 clocks → exactly 13 frame_ticks counted in WAIT, then spawn_valid rises 2 cycles after gap==0.
- Handshake stall: spawn_ready=0 for 10 cycles, then 1 → spawn_valid, lane and sprite stable through the stall. Exactly one handshake occurs, then spawn_valid=0.
- Lane rules: random_lane=1 for 5 consecutive spawns → lanes 1,1,1,2,1. random_lane=3 with last_lane=2 → lane 0.
- Abort and restart: game_reset during OFFER → spawn_valid=0 the next cycle. Also, active_count=10 during WAIT → FSM returns to IDLE with no offer.

Source files
------------

// File: rtl/obstacle_spawn_scheduler_if.sv
// Spawn offer channel from the scheduler to the obstacle pool.
interface obstacle_spawn_scheduler_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] spawn_lane;
    logic [1:0] spawn_sprite;

    modport master (
        output spawn_valid,
        output spawn_lane,
        output spawn_sprite,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        input  spawn_sprite,
        output spawn_ready
    );
endinterface

// File: rtl/obstacle_spawn_scheduler.sv
// Difficulty tracking and spawn sequencing for the runner game: paces gaps between obstacles,
// picks lane/sprite without unbeatable repeats, and offers each spawn to the pool.
module obstacle_spawn_scheduler #(
    parameter int unsigned NUM_SLOTS    = 10,
    parameter int unsigned LEVEL_PERIOD = 300,
    parameter int unsigned MAX_LEVEL    = 10,
    parameter int unsigned MIN_GAP      = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        game_reset,
    input  logic        frame_tick,
    input  logic        pause_in,
    input  logic [11:0] time_alive,
    input  logic [3:0]  active_count,
    input  logic [3:0]  random_num,
    input  logic [1:0]  random_lane,
    input  logic [1:0]  random_sprite,
    output logic [2:0]  speed,
    output logic [3:0]  target_active,
    output logic [3:0]  level,
    obstacle_spawn_scheduler_if.master spawn
);

    localparam logic [4:0]  NumSlots    = 5'(NUM_SLOTS);
    localparam logic [12:0] LevelPeriod = 13'(LEVEL_PERIOD);
    localparam logic [3:0]  MaxLevel    = 4'(MAX_LEVEL);
    localparam logic [4:0]  MinGap      = 5'(MIN_GAP);

    typedef enum logic [1:0] {StIdle, StWait, StPick, StOffer} state_e;

    state_e      state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  target_q;
    logic [2:0]  speed_q;
    logic [12:0] thr_q, thr_d;
    logic [4:0]  gap_q, gap_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  sprite_q, sprite_d;
    logic [1:0]  last_lane_q, last_lane_d;
    logic [1:0]  repeat_q, repeat_d;

    logic       srst;
    logic       slots_full;
    logic       can_start;
    logic [1:0] lane_inc;
    logic [1:0] pick_lane;

    function automatic logic [2:0] speed_of(input logic [3:0] lvl);
        logic [2:0] s;
        case (lvl)
            4'd0:        s = 3'd1;
            4'd1:        s = 3'd2;
            4'd2:        s = 3'd3;
            4'd3:        s = 3'd4;
            4'd4, 4'd5:  s = 3'd5;
            4'd6, 4'd7:  s = 3'd6;
            default:     s = 3'd7;
        endcase
        return s;
    endfunction

    assign srst       = !rst_in || game_reset;
    assign slots_full = {1'b0, active_count} >= NumSlots;
    assign can_start  = (active_count < target_q) && !slots_full && !pause_in;

    // Threshold walks up by one period per level, so no divider is needed.
    always_comb begin
        level_d = level_q;
        thr_d   = thr_q;
        if (({1'b0, time_alive} >= thr_q) && (level_q < MaxLevel)) begin
            level_d = level_q + 4'd1;
            thr_d   = thr_q + LevelPeriod;
        end
    end

    // Lane choice: invalid random lane or a fourth repeat rotates to the next lane.
    always_comb begin
        lane_inc  = (last_lane_q == 2'd2) ? 2'd0 : last_lane_q + 2'd1;
        pick_lane = random_lane;
        if (random_lane == 2'd3) begin
            pick_lane = lane_inc;
        end else if ((random_lane == last_lane_q) && (repeat_q == 2'd2)) begin
            pick_lane = lane_inc;
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        lane_d      = lane_q;
        sprite_d    = sprite_q;
        last_lane_d = last_lane_q;
        repeat_d    = repeat_q;
        unique case (state_q)
            StIdle: begin
                if (can_start) begin
                    gap_d   = MinGap + {1'b0, random_num};
                    state_d = StWait;
                end
            end
            StWait: begin
                if (slots_full) begin
                    state_d = StIdle;
                end else if (gap_q == 5'd0) begin
                    state_d = StPick;
                end else if (frame_tick && !pause_in) begin
                    gap_d = gap_q - 5'd1;
                end
            end
            StPick: begin
                lane_d   = pick_lane;
                sprite_d = random_sprite;
                state_d  = StOffer;
            end
            StOffer: begin
                if (spawn.spawn_ready) begin
                    repeat_d    = (lane_q == last_lane_q) ? repeat_q + 2'd1 : 2'd0;
                    last_lane_d = lane_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (srst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (srst) begin
            level_q     <= 4'd0;
            target_q    <= 4'd0;
            speed_q     <= 3'd1;
            thr_q       <= LevelPeriod;
            gap_q       <= 5'd0;
            lane_q      <= 2'd0;
            sprite_q    <= 2'd0;
            last_lane_q <= 2'd0;
            repeat_q    <= 2'd0;
        end else begin
            level_q     <= level_d;
            target_q    <= level_d;
            speed_q     <= speed_of(level_q);
            thr_q       <= thr_d;
            gap_q       <= gap_d;
            lane_q      <= lane_d;
            sprite_q    <= sprite_d;
            last_lane_q <= last_lane_d;
            repeat_q    <= repeat_d;
        end
    end

    assign spawn.spawn_valid  = (state_q == StOffer);
    assign spawn.spawn_lane   = lane_q;
    assign spawn.spawn_sprite = sprite_q;
    assign level              = level_q;
    assign target_active      = target_q;
    assign speed              = speed_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Self-checking bench: level/speed vector table, hand-written spawn sequences, and a randomized
// run checked against a history-based reference model.
module tb_obstacle_spawn_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        game_reset;
    logic        frame_tick;
    logic        pause_in;
    logic [11:0] time_alive;
    logic [3:0]  active_count;
    logic [3:0]  random_num;
    logic [1:0]  random_lane;
    logic [1:0]  random_sprite;
    logic [2:0]  speed;
    logic [3:0]  target_active;
    logic [3:0]  level;

    obstacle_spawn_scheduler_if sif();

    obstacle_spawn_scheduler #(
        .NUM_SLOTS(10),
        .LEVEL_PERIOD(300),
        .MAX_LEVEL(10),
        .MIN_GAP(8)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .game_reset(game_reset),
        .frame_tick(frame_tick),
        .pause_in(pause_in),
        .time_alive(time_alive),
        .active_count(active_count),
        .random_num(random_num),
        .random_lane(random_lane),
        .random_sprite(random_sprite),
        .speed(speed),
        .target_active(target_active),
        .level(level),
        .spawn(sif)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int hist[$];
    int spd_tab[11];

    typedef struct {
        int ta;
        int n;
        int lvl;
        int spd;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_game_reset();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
    endtask

    task automatic wait_valid(input int limit, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sif.spawn_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk(name, int'(got), 1);
    endtask

    function automatic int lane_ref(input int r);
        int last;
        last = hist[$];
        if (r == 3) return (last + 1) % 3;
        if (hist.size() >= 3 && hist[$] == r && hist[$-1] == r && hist[$-2] == r)
            return (last + 1) % 3;
        return r;
    endfunction

    // One full spawn with ready held high; returns the accepted lane and sprite.
    task automatic do_spawn(input int rl, input int rs, output int lane, output int sprite);
        random_lane   = 2'(rl);
        random_sprite = 2'(rs);
        active_count  = 4'd0;
        frame_tick    = 1'b1;
        random_num    = 4'd0;
        pause_in      = 1'b0;
        sif.spawn_ready = 1'b1;
        wait_valid(60, "spawn_wait");
        lane   = int'(sif.spawn_lane);
        sprite = int'(sif.spawn_sprite);
        step();
        chk("spawn_drop", int'(sif.spawn_valid), 0);
    endtask

    initial begin
        int ticks, last_tick, rise, cyc, hs, cnt, l, s;
        int exp_l[5];
        int lvl_m, spd_m, ta_i, tally, prev_lane, prev_sprite;
        bit prev_valid, prev_ready, have_hs, rst_e, hs_e, tick_e;

        spd_tab = '{1, 2, 3, 4, 5, 5, 6, 6, 7, 7, 7};
        vecs[0]  = '{ta: 0,    n: 5,  lvl: 0,  spd: 1};
        vecs[1]  = '{ta: 299,  n: 5,  lvl: 0,  spd: 1};
        vecs[2]  = '{ta: 300,  n: 1,  lvl: 1,  spd: 1};
        vecs[3]  = '{ta: 300,  n: 2,  lvl: 1,  spd: 2};
        vecs[4]  = '{ta: 900,  n: 3,  lvl: 3,  spd: 3};
        vecs[5]  = '{ta: 900,  n: 4,  lvl: 3,  spd: 4};
        vecs[6]  = '{ta: 1500, n: 6,  lvl: 5,  spd: 5};
        vecs[7]  = '{ta: 2100, n: 8,  lvl: 7,  spd: 6};
        vecs[8]  = '{ta: 4000, n: 11, lvl: 10, spd: 7};
        vecs[9]  = '{ta: 4000, n: 30, lvl: 10, spd: 7};
        vecs[10] = '{ta: 4095, n: 20, lvl: 10, spd: 7};

        rst_in = 1'b0; game_reset = 1'b0; frame_tick = 1'b0; pause_in = 1'b0;
        time_alive = 12'd900; active_count = 4'd10; random_num = 4'd0;
        random_lane = 2'd0; random_sprite = 2'd0; sif.spawn_ready = 1'b0;

        // Reset held low for three clocks with a large time_alive.
        repeat (3) step();
        chk("rst_valid", int'(sif.spawn_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_target", int'(target_active), 0);
        chk("rst_speed", int'(speed), 1);
        chk("rst_lane", int'(sif.spawn_lane), 0);
        chk("rst_sprite", int'(sif.spawn_sprite), 0);
        rst_in = 1'b1;
        repeat (3) step();
        chk("rel_level", int'(level), 3);
        step();
        chk("rel_speed", int'(speed), 4);

        // Level/speed vector table.
        foreach (vecs[i]) begin
            active_count = 4'd10;
            pulse_game_reset();
            time_alive = 12'(vecs[i].ta);
            repeat (vecs[i].n) step();
            chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
            chk($sformatf("vec%0d_target", i), int'(target_active), vecs[i].lvl);
            chk($sformatf("vec%0d_speed", i), int'(speed), vecs[i].spd);
            chk($sformatf("vec%0d_valid", i), int'(sif.spawn_valid), 0);
        end

        // Gap timing: gap 13, ticks every 4 clocks.
        time_alive = 12'd0;
        pulse_game_reset();
        time_alive = 12'd600;
        repeat (4) step();
        chk("gap_level", int'(level), 2);
        random_num = 4'd5; random_lane = 2'd1; random_sprite = 2'd2; active_count = 4'd0;
        step();
        ticks = 0; last_tick = -1; rise = -1; cyc = 0;
        for (int i = 0; i < 120 && rise < 0; i++) begin
            frame_tick = (i % 4 == 0);
            step();
            cyc++;
            if (frame_tick) begin
                ticks++;
                last_tick = cyc;
            end
            if (sif.spawn_valid) rise = cyc;
        end
        frame_tick = 1'b0;
        chk("gap_ticks", ticks, 13);
        chk("gap_latency", rise - last_tick, 2);

        // Handshake stall: offer must hold while random inputs move.
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            random_lane = 2'(i % 4); random_sprite = 2'($urandom_range(0, 3));
            if (sif.spawn_valid && sif.spawn_ready) hs++;
            step();
            chk("stall_valid", int'(sif.spawn_valid), 1);
            chk("stall_lane", int'(sif.spawn_lane), 1);
            chk("stall_sprite", int'(sif.spawn_sprite), 2);
        end
        sif.spawn_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (sif.spawn_valid && sif.spawn_ready) hs++;
            step();
            if (sif.spawn_valid) cnt++;
        end
        chk("stall_handshakes", hs, 1);
        chk("stall_after_valid", cnt, 0);

        // Lane rules from a fresh restart.
        pulse_game_reset();
        exp_l = '{1, 1, 1, 2, 1};
        for (int k = 0; k < 5; k++) begin
            do_spawn(1, k % 4, l, s);
            chk($sformatf("lane_seq%0d", k), l, exp_l[k]);
            chk($sformatf("sprite_seq%0d", k), s, k % 4);
        end
        do_spawn(2, 1, l, s);
        chk("lane_to2", l, 2);
        do_spawn(3, 3, l, s);
        chk("lane_invalid_rot", l, 0);

        // Pause freezes the countdown, then does not withdraw a live offer.
        sif.spawn_ready = 1'b0; frame_tick = 1'b0; random_num = 4'd0; active_count = 4'd0;
        step();
        pause_in = 1'b1; frame_tick = 1'b1;
        cnt = 0;
        repeat (40) begin
            step();
            if (sif.spawn_valid) cnt++;
        end
        chk("pause_frozen", cnt, 0);
        pause_in = 1'b0;
        wait_valid(30, "pause_resume");
        pause_in = 1'b1;
        cnt = 0;
        repeat (5) begin
            step();
            if (sif.spawn_valid) cnt++;
        end
        chk("pause_hold_offer", cnt, 5);
        pause_in = 1'b0;

        // game_reset during OFFER drops the offer.
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        chk("abort_offer_valid", int'(sif.spawn_valid), 0);
        chk("abort_offer_level", int'(level), 0);

        // Pool full during WAIT aborts to IDLE.
        frame_tick = 1'b0; active_count = 4'd0;
        repeat (4) step();
        active_count = 4'd10;
        step();
        frame_tick = 1'b1;
        cnt = 0;
        repeat (40) begin
            step();
            if (sif.spawn_valid) cnt++;
        end
        chk("abort_wait_no_offer", cnt, 0);
        active_count = 4'd0;
        wait_valid(40, "abort_wait_restart");
        sif.spawn_ready = 1'b1;
        step();

        // Randomized run against the reference model.
        pulse_game_reset();
        time_alive = 12'd0; ta_i = 0;
        lvl_m = 0; spd_m = 1;
        hist.delete(); hist.push_back(0);
        tally = 0; have_hs = 1'b0;
        prev_valid = sif.spawn_valid; prev_ready = 1'b0;
        prev_lane = 0; prev_sprite = 0;
        random_lane = 2'($urandom_range(0, 3)); random_sprite = 2'($urandom_range(0, 3));
        for (int c = 0; c < 3000; c++) begin
            game_reset = ($urandom_range(0, 399) == 0);
            if (game_reset) ta_i = 0;
            else ta_i = (ta_i + int'($urandom_range(0, 6)) > 4095) ? 4095
                                                                  : ta_i + int'($urandom_range(0, 6));
            time_alive = 12'(ta_i);
            frame_tick = ($urandom_range(0, 2) == 0);
            pause_in = ($urandom_range(0, 7) == 0);
            sif.spawn_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) active_count = 4'($urandom_range(0, 11));
            random_num = 4'($urandom_range(0, 15));
            rst_e = game_reset; tick_e = frame_tick;
            hs_e = sif.spawn_valid && sif.spawn_ready;
            prev_valid = sif.spawn_valid; prev_ready = sif.spawn_ready;
            prev_lane = int'(sif.spawn_lane); prev_sprite = int'(sif.spawn_sprite);
            step();
            if (rst_e) begin
                lvl_m = 0; spd_m = 1;
                hist.delete(); hist.push_back(0);
                tally = 0; have_hs = 1'b0;
            end else begin
                spd_m = spd_tab[lvl_m];
                if (lvl_m < 10 && lvl_m < ta_i / 300) lvl_m++;
                if (hs_e) begin
                    if (have_hs) chk("rand_spacing_ok", int'(tally >= 8), 1);
                    hist.push_back(prev_lane);
                    if (hist.size() > 4) void'(hist.pop_front());
                    tally = 0; have_hs = 1'b1;
                    random_lane = 2'($urandom_range(0, 3));
                    random_sprite = 2'($urandom_range(0, 3));
                end else if (tick_e) begin
                    tally++;
                end
            end
            chk("rand_level", int'(level), lvl_m);
            chk("rand_target", int'(target_active), lvl_m);
            chk("rand_speed", int'(speed), spd_m);
            if (sif.spawn_valid && !(prev_valid && !rst_e)) begin
                chk("rand_lane", int'(sif.spawn_lane), lane_ref(int'(random_lane)));
                chk("rand_sprite", int'(sif.spawn_sprite), int'(random_sprite));
            end
            if (prev_valid && !prev_ready && !rst_e) begin
                chk("rand_hold_valid", int'(sif.spawn_valid), 1);
                chk("rand_hold_lane", int'(sif.spawn_lane), prev_lane);
                chk("rand_hold_sprite", int'(sif.spawn_sprite), prev_sprite);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
